// File: rtl/width_conv_pkg.sv
// Shared helpers for the width converter: lane ratio, counter widths and
// lane extraction from a stored word.
package width_conv_pkg;

    // Widest word the lane-select helper can handle; callers zero-extend into it.
    localparam int LANE_SEL_MAX_W = 1024;

    function automatic int calc_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // Counter wide enough to hold 0..n inclusive.
    function automatic int calc_count_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // Returns the selected lane in the low out_w bits of the result.
    function automatic logic [LANE_SEL_MAX_W-1:0] lane_select(
        input logic [LANE_SEL_MAX_W-1:0] word,
        input int                        lane,
        input int                        out_w,
        input int                        ratio,
        input bit                        msb_first
    );
        int idx;
        idx = msb_first ? (ratio - 1 - lane) : lane;
        return word >> (idx * out_w);
    endfunction

endpackage

// File: rtl/width_conv_ram.sv
// Word storage for the width converter: DEPTH x IN_W simple dual-port array,
// synchronous write, asynchronous read of the head word, plus both pointers.
module width_conv_ram
    import width_conv_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [IN_W-1:0] din,
    input  logic            rd_adv,
    output logic [IN_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [IN_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is never reset; only accepted writes land here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/width_downsizer.sv
// Width downsizer: stores IN_W words and emits them as RATIO consecutive
// OUT_W units with registered dout, level counts and sticky error flags.
module width_downsizer
    import width_conv_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        flush,
    input  logic                                        wr_en,
    input  logic [IN_W-1:0]                             din,
    output logic                                        full,
    output logic [calc_count_w(DEPTH)-1:0]              wr_count,
    input  logic                                        rd_en,
    output logic [OUT_W-1:0]                            dout,
    output logic                                        valid,
    output logic                                        empty,
    output logic [calc_count_w(DEPTH*(IN_W/OUT_W))-1:0] rd_count,
    input  logic                                        err_clr,
    output logic                                        overflow,
    output logic                                        underflow
);

    localparam int RATIO  = calc_ratio(IN_W, OUT_W);
    localparam int WC_W   = calc_count_w(DEPTH);
    localparam int RC_W   = calc_count_w(DEPTH * RATIO);
    localparam int LANE_W = $clog2(RATIO);

    localparam logic [RC_W-1:0]   RATIO_RC  = RC_W'(RATIO);
    localparam logic [WC_W-1:0]   DEPTH_WC  = WC_W'(DEPTH);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);

    if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_bad_ratio
        $error("width_downsizer: IN_W must be a multiple >= 2 of OUT_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("width_downsizer: DEPTH must be a power of two >= 2");
    end
    if (IN_W >= LANE_SEL_MAX_W) begin : g_bad_width
        $error("width_downsizer: IN_W exceeds lane-select helper width");
    end

    logic                      wr_acc;
    logic                      rd_acc;
    logic                      word_free;
    logic [LANE_W-1:0]         lane;
    logic [IN_W-1:0]           head;
    logic [LANE_SEL_MAX_W-1:0] head_ext;
    logic [LANE_SEL_MAX_W-1:0] sel_word;
    logic                      unused_sel_hi;
    logic [WC_W-1:0]           wr_count_nxt;
    logic [RC_W-1:0]           rd_count_nxt;

    // flush blocks both sides; a full/empty flag blocks its own side only.
    assign wr_acc    = wr_en & ~full  & ~flush;
    assign rd_acc    = rd_en & ~empty & ~flush;
    assign word_free = rd_acc & (lane == LANE_LAST);

    width_conv_ram #(
        .IN_W  (IN_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .wr_en  (wr_acc),
        .din    (din),
        .rd_adv (word_free),
        .head   (head)
    );

    assign head_ext      = LANE_SEL_MAX_W'(head);
    assign sel_word      = lane_select(head_ext, 32'(lane), OUT_W, RATIO, MSB_FIRST);
    assign unused_sel_hi = ^sel_word[LANE_SEL_MAX_W-1:OUT_W];

    // Next-state counts; a write adds a whole word, a read removes one unit.
    always_comb begin
        wr_count_nxt = wr_count;
        rd_count_nxt = rd_count;
        if (flush) begin
            wr_count_nxt = '0;
            rd_count_nxt = '0;
        end else begin
            wr_count_nxt = wr_count + WC_W'(wr_acc) - WC_W'(word_free);
            rd_count_nxt = rd_count + (wr_acc ? RATIO_RC : '0) - RC_W'(rd_acc);
        end
    end

    // Registered level state: counts, flags and current lane of the head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
            rd_count <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            lane     <= '0;
        end else begin
            wr_count <= wr_count_nxt;
            rd_count <= rd_count_nxt;
            full     <= (wr_count_nxt == DEPTH_WC);
            empty    <= (rd_count_nxt == '0);
            if (flush) begin
                lane <= '0;
            end else if (rd_acc) begin
                lane <= word_free ? '0 : lane + 1'b1;
            end
        end
    end

    // Output register: dout only moves on an accepted read and survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= rd_acc;
            if (rd_acc) begin
                dout <= sel_word[OUT_W-1:0];
            end
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !flush) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty && !flush) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_width_downsizer.sv
// Bench for width_downsizer: unit-queue reference model with a scoreboard,
// plus a second instance (32->8, LSB first) for lane ordering.
module tb_width_downsizer;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int DEPTH = 16;
    localparam int RATIO = IN_W / OUT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              flush, wr_en, rd_en, err_clr;
    logic [IN_W-1:0]   din;
    logic              full, valid, empty, overflow, underflow;
    logic [4:0]        wr_count;
    logic [5:0]        rd_count;
    logic [OUT_W-1:0]  dout;

    logic              b_wr_en, b_rd_en;
    logic [31:0]       b_din;
    logic              b_full, b_valid, b_empty, b_overflow, b_underflow;
    logic [2:0]        b_wr_count;
    logic [4:0]        b_rd_count;
    logic [7:0]        b_dout;
    logic              b_zero;

    int checks = 0;
    int errors = 0;

    width_downsizer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .MSB_FIRST(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din),
        .full(full), .wr_count(wr_count), .rd_en(rd_en), .dout(dout),
        .valid(valid), .empty(empty), .rd_count(rd_count), .err_clr(err_clr),
        .overflow(overflow), .underflow(underflow)
    );

    assign b_zero = 1'b0;

    width_downsizer #(
        .IN_W(32), .OUT_W(8), .DEPTH(4), .MSB_FIRST(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_zero), .wr_en(b_wr_en), .din(b_din),
        .full(b_full), .wr_count(b_wr_count), .rd_en(b_rd_en), .dout(b_dout),
        .valid(b_valid), .empty(b_empty), .rd_count(b_rd_count), .err_clr(b_zero),
        .overflow(b_overflow), .underflow(b_underflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending OUT_W units plus the lane offset
    // inside the head word. Stored words = (pending units + lane) / RATIO.
    logic [OUT_W-1:0] m_units [$];
    logic [OUT_W-1:0] exp_q   [$];
    logic [OUT_W-1:0] m_dout;
    int               m_lane;
    bit               m_vld, m_ovf, m_unf;

    function automatic int m_words();
        return (m_units.size() + m_lane) / RATIO;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_units.delete();
            exp_q.delete();
            m_lane = 0;
            m_vld  = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dout = '0;
        end else begin
            bit is_full, is_empty;
            is_full  = (m_words() == DEPTH);
            is_empty = (m_units.size() == 0);
            if (flush) begin
                m_units.delete();
                m_lane = 0;
                m_vld  = 1'b0;
            end else begin
                if (rd_en && !is_empty) begin
                    m_dout = m_units.pop_front();
                    exp_q.push_back(m_dout);
                    m_lane = (m_lane + 1) % RATIO;
                    m_vld  = 1'b1;
                end else begin
                    m_vld = 1'b0;
                end
                if (wr_en && !is_full) begin
                    for (int k = 0; k < RATIO; k++) begin
                        m_units.push_back(din[(IN_W-1-k*OUT_W) -: OUT_W]);
                    end
                end
            end
            if (wr_en && is_full && !flush) m_ovf = 1'b1;
            else if (err_clr)               m_ovf = 1'b0;
            if (rd_en && is_empty && !flush) m_unf = 1'b1;
            else if (err_clr)                m_unf = 1'b0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a unit.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", 64'(valid), 64'(m_vld));
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 64'(valid), 64'(1'b0));
                end else begin
                    chk("dout", 64'(dout), 64'(exp_q.pop_front()));
                end
            end else begin
                chk("dout_hold", 64'(dout), 64'(m_dout));
            end
            chk("full",      64'(full),      64'(m_words() == DEPTH));
            chk("empty",     64'(empty),     64'(m_units.size() == 0));
            chk("wr_count",  64'(wr_count),  64'(m_words()));
            chk("rd_count",  64'(rd_count),  64'(m_units.size()));
            chk("overflow",  64'(overflow),  64'(m_ovf));
            chk("underflow", 64'(underflow), 64'(m_unf));
        end
    end

    initial begin
        logic [31:0] b_word;
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        din = '0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_din = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, two lanes, MSB first.
        wr_en = 1'b1; din = 16'hA1B2;
        @(negedge clk); wr_en = 1'b0; rd_en = 1'b1;
        @(negedge clk);
        @(negedge clk); rd_en = 1'b0;
        @(negedge clk);

        // Fill past capacity, then drain all units and two more.
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr_en = 1'b1; din = 16'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b1;
        repeat (2 * DEPTH + 2) @(negedge clk);
        rd_en = 1'b0; err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        @(negedge clk);

        // Write every second cycle with continuous reads.
        for (int i = 0; i < 40; i++) begin
            wr_en = (i % 2 == 0); din = 16'($urandom); rd_en = 1'b1;
            @(negedge clk);
            chk("wr_count_le1", 64'(wr_count <= 5'd1), 64'(1'b1));
        end
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (2) @(negedge clk);

        // Read one lane, then reset asynchronously between edges.
        wr_en = 1'b1; din = 16'h1234;
        @(negedge clk); din = 16'h5678;
        @(negedge clk); wr_en = 1'b0; rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid",    64'(valid),    64'(1'b0));
        chk("rst_dout",     64'(dout),     64'(8'h00));
        chk("rst_empty",    64'(empty),    64'(1'b1));
        chk("rst_full",     64'(full),     64'(1'b0));
        chk("rst_rd_count", 64'(rd_count), 64'(6'd0));
        chk("rst_wr_count", 64'(wr_count), 64'(5'd0));
        #1 rst_n = 1'b1;
        @(negedge clk);
        wr_en = 1'b1; din = 16'h5A6B;
        @(negedge clk); wr_en = 1'b0; rd_en = 1'b1;
        @(negedge clk);
        chk("post_rst_lane0", 64'(dout), 64'(8'h5A));
        @(negedge clk); rd_en = 1'b0;
        @(negedge clk);

        // Second instance: 32-bit word, LSB lane first.
        b_word = 32'h11223344;
        b_wr_en = 1'b1; b_din = b_word;
        @(negedge clk); b_wr_en = 1'b0;
        chk("b_rd_count_init", 64'(b_rd_count), 64'(5'd4));
        chk("b_empty_init",    64'(b_empty),    64'(1'b0));
        for (int k = 0; k < 4; k++) begin
            b_rd_en = 1'b1;
            @(negedge clk);
            chk("b_valid",    64'(b_valid),    64'(1'b1));
            chk("b_dout",     64'(b_dout),     64'(8'(b_word >> (8 * k))));
            chk("b_rd_count", 64'(b_rd_count), 64'(3 - k));
        end
        b_rd_en = 1'b0;
        @(negedge clk);
        chk("b_valid_end", 64'(b_valid), 64'(1'b0));
        chk("b_empty_end", 64'(b_empty), 64'(1'b1));

        // Random traffic with occasional flush and error clear.
        for (int i = 0; i < 800; i++) begin
            wr_en   = ($urandom_range(0, 99) < 55);
            rd_en   = ($urandom_range(0, 99) < 50);
            flush   = ($urandom_range(0, 99) < 3);
            err_clr = ($urandom_range(0, 99) < 4);
            din     = 16'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drain", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/width_downsizer.md
WIDTH_DOWNSIZER -- requirements
Module: width_downsizer

Interface
REQ-001 Parameter IN_W, default 16, SHALL be the write word width in bits.
REQ-002 Parameter OUT_W, default 8, SHALL be the read word width; IN_W SHALL be an integer multiple RATIO = IN_W/OUT_W, with RATIO >= 2 (elaboration error otherwise).
REQ-003 Parameter DEPTH, default 16, SHALL be the storage depth in IN_W words; it SHALL be a power of two >= 2.
REQ-004 Parameter MSB_FIRST, default 1, SHALL select lane order: 1 = din[IN_W-1 -: OUT_W] emitted first, 0 = din[OUT_W-1:0] emitted first.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 flush  in  1  synchronous clear of stored data.
REQ-008 wr_en  in  1  write strobe.
REQ-009 din  in  IN_W  write data.
REQ-010 full  out  1  no free word slot.
REQ-011 wr_count  out  clog2(DEPTH)+1  stored words, including a partially read word.
REQ-012 rd_en  in  1  read strobe, one OUT_W unit per cycle.
REQ-013 dout  out  OUT_W  registered read data.
REQ-014 valid  out  1  dout holds a unit popped on the previous cycle.
REQ-015 empty  out  1  no unread unit.
REQ-016 rd_count  out  clog2(DEPTH*RATIO)+1  unread OUT_W units.
REQ-017 err_clr  in  1  clears sticky error flags.
REQ-018 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-019 A write SHALL be accepted when wr_en=1, full=0 and flush=0; the word is stored at the write pointer, which advances modulo DEPTH.
REQ-020 A write with full=1 SHALL be dropped and SHALL set overflow, even if a word is freed in the same cycle.
REQ-021 full, empty, wr_count and rd_count SHALL be registered and SHALL reflect an accepted write or read on the following cycle.
REQ-022 rd_count SHALL equal wr_count*RATIO - lane, where lane (0..RATIO-1) is the index of the next unit in the head word.
REQ-023 A read SHALL be accepted when rd_en=1, empty=0 and flush=0; dout SHALL update with the selected lane of the head word and valid SHALL be 1 on the next cycle (latency 1).
REQ-024 If rd_en is not accepted, valid SHALL be 0 on the next cycle and dout SHALL hold its value.
REQ-025 After an accepted read, lane SHALL increment; when the read takes lane RATIO-1, lane SHALL wrap to 0, the read pointer SHALL advance modulo DEPTH and the word SHALL be freed.
REQ-026 rd_en with empty=1 SHALL be ignored and SHALL set underflow.
REQ-027 A simultaneous accepted write and word-freeing read SHALL leave wr_count unchanged.
REQ-028 A write to an empty block SHALL be readable on the cycle after empty deasserts; no combinational path SHALL exist from din to dout.
REQ-029 flush=1 SHALL zero both pointers, lane, wr_count, rd_count and valid, and SHALL assert empty on the next cycle; it SHALL take priority over wr_en and rd_en, and dout and the error flags SHALL be retained.
REQ-030 err_clr=1 SHALL clear overflow and underflow on the next cycle; a new error in the same cycle SHALL take priority and leave the flag set.

Reset
REQ-031 rst_n=0 SHALL immediately clear the pointers, lane, counts, dout, valid, overflow and underflow, and SHALL set empty=1 and full=0.
REQ-032 Storage contents SHALL NOT be reset.
REQ-033 Reset asserted mid-word SHALL discard the partial word; the first read after release SHALL return lane 0 of the next written word.

Structure
REQ-034 Package width_conv_pkg SHALL hold the RATIO and count-width calculation functions and a lane-select function that takes (word, lane, MSB_FIRST).
REQ-035 Word storage and pointers SHALL be in sub-module width_conv_ram, a DEPTH x IN_W simple dual-port array with a synchronous write and an asynchronous head read. The lane, flag, count and error logic SHALL be in the top level.

Verification
REQ-036 Default parameters: write 0xA1B2, then hold rd_en for 2 cycles -> dout 0xA1 then 0xB2, valid=1 on both, empty=1 afterwards.
REQ-037 MSB_FIRST=0, IN_W=32, OUT_W=8: write 0x11223344, read 4 units -> 0x44, 0x33, 0x22, 0x11; rd_count steps 4, 3, 2, 1, 0.
REQ-038 Write 17 words with DEPTH=16 and no reads -> full=1 after the 16th write, overflow=1, and reads return words 0-15 in order.
REQ-039 rd_en while empty -> valid=0, dout unchanged, underflow=1; err_clr -> underflow=0.
REQ-040 Continuous wr_en every 2nd cycle with continuous rd_en (RATIO=2) -> no loss, no overflow, ordered output, wr_count never exceeds 1.
REQ-041 Read 1 of 2 lanes, then pulse rst_n low asynchronously between clock edges -> outputs cleared without a clk edge; next word is read from lane 0.
